iter_divider: RTL and testbench

ITER_DIVIDER -- requirements
Module: iter_divider

---
 rtl/iter_divider_if.sv | 31 +++
 rtl/iter_divider.sv | 138 +++++++++++++
 tb/tb_iter_divider.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/iter_divider_if.sv
// iter_divider_if
//   Operand/result handshake bundle for iter_divider.
//   slave  : the divider (accepts operands, presents results)
//   master : the producer/consumer driving it
//   Signals:
//     in_valid, dividend[7:0], divisor[3:0]     operand side (master -> slave)
//     in_ready                                   operand side (slave -> master)
//     out_valid, quotient[7:0], remainder[3:0],
//     div_by_zero                                result side (slave -> master)
//     out_ready                                  result side (master -> slave)
interface iter_divider_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iter_divider.sv
// iter_divider
//   8-bit / 4-bit unsigned restoring divider, one quotient bit per cycle.
//   Ports:
//     clk    sole clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    iter_divider_if.slave (operand and result handshakes)
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | in_ready = 1, waiting for an operand pair
//   CALC  | 8 restoring iterations, MSB of dividend first
//   DONE  | out_valid = 1, result held until out_ready
module iter_divider (
  input  logic           clk,
  input  logic           rst_n,
  iter_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  // r_acc shifts dividend bits out of the top while quotient bits enter at
  // the bottom, so after 8 iterations it holds the whole quotient.
  logic [7:0] r_acc;
  logic [3:0] r_divisor;
  logic [3:0] r_rem;
  logic [2:0] r_cnt;

  // Result registers are separate from the working registers so the
  // visible outputs keep the previous result while a new division runs.
  logic [7:0] r_quot;
  logic [3:0] r_rem_o;
  logic       r_dbz;

  logic       w_accept;
  logic       w_in_ready;
  logic       w_out_valid;
  logic [4:0] w_trial;
  logic [4:0] w_diff;
  logic       w_qbit;
  logic [3:0] w_rem_nxt;

  assign w_accept  = bus.in_valid & w_in_ready;
  assign w_trial   = {r_rem, r_acc[7]};
  assign w_diff    = w_trial - {1'b0, r_divisor};
  assign w_qbit    = (w_trial >= {1'b0, r_divisor});
  // Without subtraction the trial value is below the divisor, so it fits 4 bits.
  assign w_rem_nxt = w_qbit ? w_diff[3:0] : w_trial[3:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt = (bus.divisor == 4'd0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_cnt == 3'd7) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= 8'd0;
      r_divisor <= 4'd0;
      r_rem     <= 4'd0;
      r_cnt     <= 3'd0;
      r_quot    <= 8'd0;
      r_rem_o   <= 4'd0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc     <= bus.dividend;
            r_divisor <= bus.divisor;
            r_rem     <= 4'd0;
            r_cnt     <= 3'd0;
            if (bus.divisor == 4'd0) begin
              r_quot  <= 8'hFF;
              r_rem_o <= bus.dividend[3:0];
              r_dbz   <= 1'b1;
            end
          end
        end
        CALC: begin
          r_acc <= {r_acc[6:0], w_qbit};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_quot  <= {r_acc[6:0], w_qbit};
            r_rem_o <= w_rem_nxt;
            r_dbz   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem_o;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider
//   Directed cases plus a shuffled sweep of every operand pair, checked
//   against plain integer division in the bench.
module tb_iter_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  iter_divider_if bus ();

  iter_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] last_q = 8'd0;
  logic [3:0] last_r = 4'd0;
  logic       last_z = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait for the result, optional backpressure,
  // then handoff. hold == 0 keeps out_ready high the whole time.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int hold);
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;
    int         lat;
    int         elat;
    eq   = (b == 4'd0) ? 8'hFF : 8'(int'(a) / int'(b));
    er   = (b == 4'd0) ? a[3:0] : 4'(int'(a) % int'(b));
    ez   = (b == 4'd0);
    elat = (b == 4'd0) ? 1 : 9;

    check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = (hold == 0);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
    if (b != 4'd0) begin
      check("in_ready_calc", {31'd0, bus.in_ready}, 32'd0);
      check("keep_q_calc", {24'd0, bus.quotient}, {24'd0, last_q});
      check("keep_r_calc", {28'd0, bus.remainder}, {28'd0, last_r});
      check("keep_z_calc", {31'd0, bus.div_by_zero}, {31'd0, last_z});
    end
    while (!bus.out_valid && lat < elat + 4) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    check("latency", lat, elat);
    check("quotient", {24'd0, bus.quotient}, {24'd0, eq});
    check("remainder", {28'd0, bus.remainder}, {28'd0, er});
    check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, ez});

    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.dividend = 8'($urandom);
      bus.divisor  = 4'($urandom);
      @(posedge clk); #1;
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("hold_q", {24'd0, bus.quotient}, {24'd0, eq});
      check("hold_r", {28'd0, bus.remainder}, {28'd0, er});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("handoff_valid", {31'd0, bus.out_valid}, 32'd0);
    check("handoff_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("idle_keep_q", {24'd0, bus.quotient}, {24'd0, eq});
    bus.out_ready = 1'b0;
    last_q = eq;
    last_r = er;
    last_z = ez;
  endtask

  initial begin
    int start;
    int stride;
    int idx;
    int saw_valid;

    bus.in_valid  = 1'b0;
    bus.dividend  = 8'd0;
    bus.divisor   = 4'd0;
    bus.out_ready = 1'b0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_quotient", {24'd0, bus.quotient}, 32'd0);
    check("rst_remainder", {28'd0, bus.remainder}, 32'd0);
    check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    run_op(8'd200, 4'd7, 0);
    run_op(8'd255, 4'd1, 0);
    run_op(8'd0,   4'd5, 0);
    run_op(8'd9,   4'd15, 0);
    run_op(8'hA7,  4'd0, 0);
    run_op(8'd100, 4'd9, 20);

    // Abort a division 4 cycles into CALC.
    bus.out_ready = 1'b1;
    bus.dividend  = 8'd77;
    bus.divisor   = 4'd3;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_quotient", {24'd0, bus.quotient}, 32'd0);
    check("abort_remainder", {28'd0, bus.remainder}, 32'd0);
    check("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    saw_valid = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_valid = 1;
    end
    check("abort_no_valid", saw_valid, 0);
    bus.out_ready = 1'b0;
    last_q = 8'd0;
    last_r = 4'd0;
    last_z = 1'b0;
    run_op(8'd50, 4'd6, 0);

    // Shuffled visit of all 4096 operand pairs (odd stride is a permutation).
    start  = int'($urandom_range(0, 4095));
    stride = int'(($urandom | 32'd1) & 32'hFFF);
    for (int i = 0; i < 4096; i++) begin
      idx = (start + i * stride) % 4096;
      run_op(8'(idx >> 4), 4'(idx), ($urandom_range(0, 7) == 0) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
